// File: rtl/sap_ctrl_seq.sv
// sap_ctrl_seq: instruction-cycle sequencer for the 16-bit SAP computer
// Ports: clk, rst (async active-low); run starts from IDLE; ir_in holds the
// current instruction (opcode [15:12]); flag_c/flag_z are ALU flags; mem_ready
// completes a memory access. Outputs are the datapath control strobes, halted,
// sticky bus_err on memory timeout, and the 3-bit state encoding.
module sap_ctrl_seq #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] ir_in,
  input  logic        flag_c,
  input  logic        flag_z,
  input  logic        mem_ready,
  output logic        pc_inc,
  output logic        pc_write,
  output logic        pc_oe,
  output logic        mar_load,
  output logic        mem_re,
  output logic        mem_we,
  output logic        mem_oe,
  output logic        ir_load,
  output logic        ir_oe,
  output logic        a_load,
  output logic        a_oe,
  output logic        b_load,
  output logic        alu_oe,
  output logic        alu_sub,
  output logic        flags_load,
  output logic        out_load,
  output logic        halted,
  output logic        bus_err,
  output logic [2:0]  state
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] F0   = 3'd1;
  localparam logic [2:0] F1   = 3'd2;
  localparam logic [2:0] DEC  = 3'd3;
  localparam logic [2:0] E0   = 3'd4;
  localparam logic [2:0] E1   = 3'd5;
  localparam logic [2:0] E2   = 3'd6;
  localparam logic [2:0] HALT = 3'd7;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [3:0]    op;
  logic [CW-1:0] cnt;
  logic [2:0]    nxt;
  logic          mem_st, tmo, ok, e0, e1, e2;
  logic          lda, add, sub, sta, ldi, jmp, jc, jz, outi, memop;
  logic          unused_ir;
  assign unused_ir = ^ir_in[11:0];
  assign e0     = state == E0;
  assign e1     = state == E1;
  assign e2     = state == E2;
  assign lda    = op == 4'd1;
  assign add    = op == 4'd2;
  assign sub    = op == 4'd3;
  assign sta    = op == 4'd4;
  assign ldi    = op == 4'd5;
  assign jmp    = op == 4'd6;
  assign jc     = op == 4'd7;
  assign jz     = op == 4'd8;
  assign outi   = op == 4'd14;
  assign memop  = lda | add | sub | sta;
  assign mem_st = state == F1 || e1;
  assign ok     = mem_st && mem_ready;
  // Abort on the cycle the wait count would reach TIMEOUT; a ready in that
  // same cycle still wins because tmo requires mem_ready low.
  assign tmo    = mem_st && !mem_ready && cnt == CW'(TIMEOUT - 1);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = run ? F0 : IDLE;
      F0:      nxt = F1;
      F1:      nxt = mem_ready ? DEC : tmo ? HALT : F1;
      DEC:     nxt = ir_in[15:12] == 4'd15 ? HALT : E0;
      E0:      nxt = memop ? E1 : F0;
      E1:      nxt = mem_ready ? ((add | sub) ? E2 : F0) : tmo ? HALT : E1;
      E2:      nxt = F0;
      default: nxt = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      op      <= '0;
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      state <= nxt;
      if (state == DEC) op <= ir_in[15:12];
      cnt <= (mem_st && !mem_ready) ? cnt + 1'b1 : '0;
      if (tmo) bus_err <= 1'b1;
    end
  assign pc_oe      = state == F0;
  assign mar_load   = state == F0 || (e0 && memop);
  assign mem_re     = state == F1 || (e1 && !sta);
  assign mem_we     = e1 && sta;
  assign mem_oe     = ok && !(e1 && sta);
  assign ir_load    = state == F1 && mem_ready;
  assign pc_inc     = state == F1 && mem_ready;
  assign ir_oe      = e0 && (memop | ldi | jmp | jc | jz);
  assign a_load     = (e1 && lda && mem_ready) || (e0 && ldi) || e2;
  assign a_oe       = (e1 && sta) || (e0 && outi);
  assign b_load     = e1 && (add | sub) && mem_ready;
  assign alu_oe     = e2;
  assign alu_sub    = e2 && sub;
  assign flags_load = e2;
  assign pc_write   = e0 && (jmp || (jc && flag_c) || (jz && flag_z));
  assign out_load   = e0 && outi;
  assign halted     = state == HALT;
endmodule

// File: tb/tb_sap_ctrl_seq.sv
// tb_sap_ctrl_seq: scoreboard bench for the SAP instruction sequencer
module tb_sap_ctrl_seq;
  logic clk, rst, run, flag_c, flag_z, mem_ready;
  logic [15:0] ir_in;
  logic pc_inc, pc_write, pc_oe, mar_load, mem_re, mem_we, mem_oe, ir_load, ir_oe;
  logic a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, out_load, halted, bus_err;
  logic [2:0] state;
  sap_ctrl_seq #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .run(run), .ir_in(ir_in), .flag_c(flag_c), .flag_z(flag_z),
    .mem_ready(mem_ready), .pc_inc(pc_inc), .pc_write(pc_write), .pc_oe(pc_oe),
    .mar_load(mar_load), .mem_re(mem_re), .mem_we(mem_we), .mem_oe(mem_oe),
    .ir_load(ir_load), .ir_oe(ir_oe), .a_load(a_load), .a_oe(a_oe), .b_load(b_load),
    .alu_oe(alu_oe), .alu_sub(alu_sub), .flags_load(flags_load), .out_load(out_load),
    .halted(halted), .bus_err(bus_err), .state(state)
  );
  localparam logic [17:0] PI = 18'h20000, PW = 18'h10000, PO = 18'h08000, ML = 18'h04000;
  localparam logic [17:0] MR = 18'h02000, MW = 18'h01000, MO = 18'h00800, IL = 18'h00400;
  localparam logic [17:0] IO = 18'h00200, AL = 18'h00100, AO = 18'h00080, BL = 18'h00040;
  localparam logic [17:0] XO = 18'h00020, XS = 18'h00010, FL = 18'h00008, OL = 18'h00004;
  localparam logic [17:0] HL = 18'h00002, BE = 18'h00001;
  localparam logic [17:0] FETCH = MR | MO | IL | PI;
  logic [17:0] obs;
  assign obs = {pc_inc, pc_write, pc_oe, mar_load, mem_re, mem_we, mem_oe, ir_load, ir_oe,
                a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, out_load, halted, bus_err};
  typedef struct {
    string       nm;
    logic [2:0]  st;
    logic [17:0] v;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  event aev;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask
  initial forever begin
    @(negedge clk or aev);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.nm, " state"}, 32'(state), 32'(e.st));
      chk({e.nm, " strobes"}, 32'(obs), 32'(e.v));
      chk({e.nm, " pc_inc&pc_write"}, 32'(pc_inc & pc_write), 0);
      chk({e.nm, " drivers"}, 32'(pc_oe) + 32'(mem_oe) + 32'(ir_oe) + 32'(a_oe) + 32'(alu_oe) > 1 ? 1 : 0, 0);
      chk({e.nm, " re&we"}, 32'(mem_re & mem_we), 0);
    end
  end
  task automatic step(input string nm, input logic rs, input logic r, input logic [15:0] ir,
                      input logic c, input logic z, input logic rdy,
                      input logic [2:0] es, input logic [17:0] ev);
    exp_t x;
    @(negedge clk);
    rst = rs; run = r; ir_in = ir; flag_c = c; flag_z = z; mem_ready = rdy;
    x.nm = nm; x.st = es; x.v = ev;
    q.push_back(x);
  endtask
  task automatic fetch_dec(input string nm, input logic [15:0] ir);
    step({nm, " f0"}, 1, 0, ir, 0, 0, 1, 3'd1, PO | ML);
    step({nm, " f1"}, 1, 0, ir, 0, 0, 1, 3'd2, FETCH);
    step({nm, " dec"}, 1, 0, ir, 0, 0, 1, 3'd3, 18'h0);
  endtask
  task automatic e0(input string nm, input logic [15:0] ir, input logic c, input logic z,
                    input logic [17:0] ev);
    fetch_dec(nm, ir);
    step({nm, " e0"}, 1, 0, ir, c, z, 1, 3'd4, ev);
  endtask
  initial begin
    exp_t x;
    rst = 1; run = 0; ir_in = 0; flag_c = 0; flag_z = 0; mem_ready = 0;
    #1 rst = 0;
    step("rst0", 0, 1, 16'h5042, 0, 0, 1, 3'd0, 18'h0);
    step("rst1", 0, 1, 16'h5042, 0, 0, 1, 3'd0, 18'h0);
    step("idle", 1, 1, 16'h5042, 0, 0, 1, 3'd0, 18'h0);
    e0("ldi", 16'h5042, 0, 0, IO | AL);
    fetch_dec("add", 16'h2010);
    step("add e0", 1, 0, 16'h2010, 0, 0, 1, 3'd4, IO | ML);
    for (int i = 0; i < 3; i++) step("add wait", 1, 0, 16'h2010, 0, 0, 0, 3'd5, MR);
    step("add e1", 1, 0, 16'h2010, 0, 0, 1, 3'd5, MR | MO | BL);
    step("add e2", 1, 0, 16'h2010, 0, 0, 1, 3'd6, XO | AL | FL);
    fetch_dec("sub", 16'h3010);
    step("sub e0", 1, 0, 16'h3010, 0, 0, 1, 3'd4, IO | ML);
    step("sub e1", 1, 0, 16'h3010, 0, 0, 1, 3'd5, MR | MO | BL);
    step("sub e2", 1, 0, 16'h3010, 0, 0, 1, 3'd6, XO | XS | AL | FL);
    e0("jc c0", 16'h7020, 0, 1, IO);
    e0("jc c1", 16'h7020, 1, 0, IO | PW);
    e0("jz z1", 16'h8000, 0, 1, IO | PW);
    e0("jz z0", 16'h8000, 1, 0, IO);
    e0("jmp", 16'h6005, 0, 0, IO | PW);
    e0("out", 16'hE000, 0, 0, AO | OL);
    e0("nop", 16'h0000, 1, 1, 18'h0);
    e0("undef", 16'h9000, 1, 1, 18'h0);
    e0("lda", 16'h1033, 0, 0, IO | ML);
    step("lda e1", 1, 0, 16'h1033, 0, 0, 1, 3'd5, MR | MO | AL);
    e0("sta", 16'h4020, 0, 0, IO | ML);
    step("sta wait", 1, 0, 16'h4020, 0, 0, 0, 3'd5, AO | MW);
    step("sta e1", 1, 0, 16'h4020, 0, 0, 1, 3'd5, AO | MW);
    e0("sta2", 16'h4020, 0, 0, IO | ML);
    step("sta2 wait", 1, 0, 16'h4020, 0, 0, 0, 3'd5, AO | MW);
    #3 rst = 0;
    x.nm = "async rst"; x.st = 3'd0; x.v = 18'h0;
    q.push_back(x);
    -> aev;
    step("in rst", 0, 1, 16'h4020, 0, 0, 0, 3'd0, 18'h0);
    step("idle2", 1, 1, 16'hF000, 0, 0, 1, 3'd0, 18'h0);
    fetch_dec("hlt", 16'hF000);
    for (int i = 0; i < 3; i++) step("halt", 1, i[0], 16'h5042, 0, 0, 1, 3'd7, HL);
    step("halt rst", 0, 0, 16'h5042, 0, 0, 1, 3'd0, 18'h0);
    step("idle3", 1, 1, 16'h5042, 0, 0, 0, 3'd0, 18'h0);
    step("tmo f0", 1, 0, 16'h5042, 0, 0, 0, 3'd1, PO | ML);
    for (int i = 0; i < 15; i++) step("tmo f1", 1, 0, 16'h5042, 0, 0, 0, 3'd2, MR);
    step("tmo halt", 1, 1, 16'h5042, 0, 0, 1, 3'd7, HL | BE);
    step("tmo halt2", 1, 1, 16'h5042, 0, 0, 1, 3'd7, HL | BE);
    step("tmo rst", 0, 1, 16'h5042, 0, 0, 1, 3'd0, 18'h0);
    step("idle4", 1, 1, 16'h5042, 0, 0, 0, 3'd0, 18'h0);
    step("late f0", 1, 0, 16'h5042, 0, 0, 0, 3'd1, PO | ML);
    for (int i = 0; i < 14; i++) step("late f1", 1, 0, 16'h5042, 0, 0, 0, 3'd2, MR);
    step("late ready", 1, 0, 16'h5042, 0, 0, 1, 3'd2, FETCH);
    step("late dec", 1, 0, 16'h5042, 0, 0, 1, 3'd3, 18'h0);
    step("late e0", 1, 0, 16'h5042, 0, 0, 1, 3'd4, IO | AL);
    e0("lda2", 16'h1040, 0, 0, IO | ML);
    for (int i = 0; i < 15; i++) step("e1 wait", 1, 0, 16'h1040, 0, 0, 0, 3'd5, MR);
    step("e1 tmo", 1, 0, 16'h1040, 0, 0, 1, 3'd7, HL | BE);
    @(negedge clk);
    #3;
    chk("queue drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
